// File: rtl/scpu_int_ctrl_if.sv
// Bus between the SCPU core (master) and its interrupt controller (slave).
// It carries the IRQ sources, the mask access, the INT request and the ack/eret handshake.
interface scpu_int_ctrl_if #(
  parameter int N_IRQ = 8
);
  localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  logic [N_IRQ-1:0] irq_in;
  logic             mask_we;
  logic [N_IRQ-1:0] mask_wdata;
  logic [N_IRQ-1:0] mask_out;
  logic [N_IRQ-1:0] pending_out;
  logic             int_ack;
  logic             int_eret;
  logic             INT;
  logic [ID_W-1:0]  irq_id;
  logic [31:0]      vec_addr;

  modport master (
    output irq_in, mask_we, mask_wdata, int_ack, int_eret,
    input  mask_out, pending_out, INT, irq_id, vec_addr
  );

  modport slave (
    input  irq_in, mask_we, mask_wdata, int_ack, int_eret,
    output mask_out, pending_out, INT, irq_id, vec_addr
  );
endinterface

// File: rtl/scpu_int_ctrl.sv
// Interrupt controller for the SCPU. It edge-detects N_IRQ sources, masks them and selects by fixed priority (bit 0 wins).
// It holds INT and the handler vector until the CPU acks, then blocks further requests until ERET.
module scpu_int_ctrl #(
  parameter int          N_IRQ      = 8,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0004,
  parameter logic [31:0] VEC_STRIDE = 32'd4
) (
  input logic           clk,
  input logic           reset,
  scpu_int_ctrl_if.slave bus
);
  localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  function automatic logic [ID_W-1:0] lowest_idx(input logic [N_IRQ-1:0] v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (v[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [31:0] vec_of(input logic [ID_W-1:0] id);
    return VEC_BASE + (32'(id) * VEC_STRIDE);
  endfunction

  state_t           state;
  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] mask;
  logic             int_q;
  logic [ID_W-1:0]  id_q;
  logic [31:0]      vec_q;

  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] cand;
  logic [N_IRQ-1:0] clr;
  logic [ID_W-1:0]  sel;

  always_comb begin
    rise = bus.irq_in & ~irq_q;
    cand = pending & mask;
    sel  = lowest_idx(cand);
    clr  = '0;
    if (state == REQ && bus.int_ack) clr = N_IRQ'(1) << id_q;
  end

  // The edge history keeps tracking irq_in through reset, so a line already high when reset drops is not a new edge.
  always_ff @(posedge clk) begin
    irq_q <= bus.irq_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
      mask    <= '0;
      int_q   <= 1'b0;
      id_q    <= '0;
      vec_q   <= VEC_BASE;
    end else begin
      // set beats clear: a fresh edge on the source being acked stays pending
      pending <= (pending & ~clr) | rise;
      if (bus.mask_we) mask <= bus.mask_wdata;
      case (state)
        IDLE: begin
          if (cand != '0) begin
            id_q  <= sel;
            vec_q <= vec_of(sel);
            int_q <= 1'b1;
            state <= REQ;
          end
        end
        REQ: begin
          if (bus.int_ack) begin
            int_q <= 1'b0;
            state <= SERVICE;
          end else if (!mask[id_q]) begin
            int_q <= 1'b0;
            state <= IDLE;
          end
        end
        SERVICE: begin
          if (bus.int_eret) state <= IDLE;
        end
        default: begin
          int_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mask_out    = mask;
  assign bus.pending_out = pending;
  assign bus.INT         = int_q;
  assign bus.irq_id      = id_q;
  assign bus.vec_addr    = vec_q;
endmodule

// File: tb/tb_scpu_int_ctrl.sv
// Bench for scpu_int_ctrl: directed scenarios followed by random traffic.
// Every cycle is compared against a cycle-level behavioural model of the controller.
module tb_scpu_int_ctrl;
  localparam int          N_IRQ      = 8;
  localparam logic [31:0] VEC_BASE   = 32'h0000_0004;
  localparam logic [31:0] VEC_STRIDE = 32'd4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  scpu_int_ctrl_if #(.N_IRQ(N_IRQ)) bus();

  scpu_int_ctrl #(
    .N_IRQ(N_IRQ), .VEC_BASE(VEC_BASE), .VEC_STRIDE(VEC_STRIDE)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // The model tracks whether a request is outstanding and whether a handler is running.
  logic [7:0]  m_prev, m_pend, m_mask;
  bit          m_int, m_busy;
  int          m_id;
  logic [31:0] m_vec;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [7:0] edges, ready, drop;
    edges = bus.irq_in & ~m_prev;
    ready = m_pend & m_mask;
    drop  = '0;
    if (reset) begin
      m_pend = '0; m_mask = '0; m_int = 0; m_busy = 0; m_id = 0; m_vec = VEC_BASE;
    end else begin
      if (m_int) begin
        if (bus.int_ack) begin
          drop[m_id] = 1'b1; m_int = 0; m_busy = 1;
        end else if (!m_mask[m_id]) begin
          m_int = 0;
        end
      end else if (m_busy) begin
        if (bus.int_eret) m_busy = 0;
      end else if (ready != 0) begin
        for (int i = 7; i >= 0; i--) if (ready[i]) m_id = i;
        m_vec = VEC_BASE + m_id * VEC_STRIDE;
        m_int = 1;
      end
      m_pend = (m_pend & ~drop) | edges;
      if (bus.mask_we) m_mask = bus.mask_wdata;
    end
    m_prev = bus.irq_in;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("INT",      32'(bus.INT),         32'(m_int));
    chk("pending",  32'(bus.pending_out), 32'(m_pend));
    chk("mask",     32'(bus.mask_out),    32'(m_mask));
    chk("irq_id",   32'(bus.irq_id),      32'(m_id));
    chk("vec_addr", bus.vec_addr,         m_vec);
  endtask

  task automatic ack();
    bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
  endtask

  task automatic eret();
    bus.int_eret = 1'b1; step(); bus.int_eret = 1'b0;
  endtask

  task automatic write_mask(input logic [7:0] m);
    bus.mask_we = 1'b1; bus.mask_wdata = m; step(); bus.mask_we = 1'b0;
  endtask

  initial begin
    m_prev = '0; m_pend = '0; m_mask = '0; m_int = 0; m_busy = 0; m_id = 0; m_vec = VEC_BASE;
    bus.irq_in = '0; bus.mask_we = 0; bus.mask_wdata = '0; bus.int_ack = 0; bus.int_eret = 0;
    #2;

    // reset with all sources high; held-high lines must not create requests
    reset = 1'b1; bus.irq_in = 8'hFF;
    step(); step();
    chk("rst_INT", 32'(bus.INT), 32'd0);
    chk("rst_pend", 32'(bus.pending_out), 32'd0);
    chk("rst_vec", bus.vec_addr, 32'h4);
    reset = 1'b0;
    step(); step();
    write_mask(8'hFF);
    step(); step();
    chk("held_INT", 32'(bus.INT), 32'd0);
    chk("held_pend", 32'(bus.pending_out), 32'd0);
    bus.irq_in = 8'h00; step();

    // single source
    bus.irq_in = 8'h08; step();
    chk("single_pend", 32'(bus.pending_out), 32'h08);
    chk("single_INT0", 32'(bus.INT), 32'd0);
    step();
    chk("single_INT1", 32'(bus.INT), 32'd1);
    chk("single_id", 32'(bus.irq_id), 32'd3);
    chk("single_vec", bus.vec_addr, 32'h10);
    ack();
    chk("single_ackINT", 32'(bus.INT), 32'd0);
    chk("single_ackpend", 32'(bus.pending_out), 32'd0);
    eret(); bus.irq_in = 8'h00; step();

    // simultaneous sources, priority order
    bus.irq_in = 8'h24; step(); step();
    chk("prio_id", 32'(bus.irq_id), 32'd2);
    chk("prio_vec", bus.vec_addr, 32'h0C);
    ack(); eret(); step();
    chk("prio2_INT", 32'(bus.INT), 32'd1);
    chk("prio2_id", 32'(bus.irq_id), 32'd5);
    chk("prio2_vec", bus.vec_addr, 32'h18);
    ack(); eret(); bus.irq_in = 8'h00; step();

    // masking
    write_mask(8'h00);
    bus.irq_in = 8'h02; step();
    chk("mask_pend", 32'(bus.pending_out), 32'h02);
    step(); step();
    chk("mask_INT0", 32'(bus.INT), 32'd0);
    write_mask(8'h02);
    step();
    chk("mask_INT1", 32'(bus.INT), 32'd1);
    write_mask(8'h00);
    step();
    chk("maskdrop_INT", 32'(bus.INT), 32'd0);
    chk("maskdrop_pend", 32'(bus.pending_out), 32'h02);
    write_mask(8'hFF); step();
    ack(); eret(); bus.irq_in = 8'h00; step();

    // no nesting while in service
    bus.irq_in = 8'h40; step(); step(); ack();
    bus.irq_in = 8'h41; step(); step(); step();
    chk("nest_INT0", 32'(bus.INT), 32'd0);
    eret();
    chk("nest_eretINT", 32'(bus.INT), 32'd0);
    step();
    chk("nest_INT1", 32'(bus.INT), 32'd1);
    chk("nest_id", 32'(bus.irq_id), 32'd0);
    ack(); eret(); bus.irq_in = 8'h00; step();

    // fresh edge racing the ack of the same source
    bus.irq_in = 8'h10; step(); step();
    chk("race_id", 32'(bus.irq_id), 32'd4);
    bus.irq_in = 8'h00; step();
    bus.irq_in = 8'h10; ack();
    chk("race_pend", 32'(bus.pending_out), 32'h10);
    eret(); step();
    chk("race_INT", 32'(bus.INT), 32'd1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("rstreq_INT", 32'(bus.INT), 32'd0);
    chk("rstreq_pend", 32'(bus.pending_out), 32'd0);
    chk("rstreq_mask", 32'(bus.mask_out), 32'd0);
    write_mask(8'hFF);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      bus.irq_in     = bus.irq_in ^ 8'($urandom & $urandom & $urandom);
      bus.mask_we    = ($urandom_range(0, 9) == 0);
      bus.mask_wdata = 8'($urandom | $urandom);
      bus.int_ack    = ($urandom_range(0, 2) == 0);
      bus.int_eret   = ($urandom_range(0, 3) == 0);
      reset          = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0; bus.int_ack = 0; bus.int_eret = 0; bus.mask_we = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
